// File: rtl/hex_disp_pkg.sv
// Shared 7-segment display types and the nibble-to-glyph decoder.
// Combinational helpers only; no latency and no backpressure.
package hex_disp_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, SEEK} sched_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] nibble_to_seg(input logic [3:0] n);
        logic [6:0] seg;
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts enabled cycles and flags the last one of each DWELL window.
// expire is combinational from the count; wraps to zero after expiry; clr wins over en.
// No backpressure: en simply freezes the count.
module dwell_timer #(
    parameter int DWELL = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(DWELL);
    localparam logic [W-1:0] LAST = W'(DWELL - 1);

    logic [W-1:0] cnt;

    assign expire = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= expire ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/hex_display_sched.sv
// Round-robin scheduler time-sharing the HEX displays between NSRC sources, with hold/advance.
// Segments lag the shown source's data by 2 cycles; SEEK examines one candidate per cycle.
// hold freezes the dwell and masks adv; optional HEX_ZERO_BLANK_EN blanks leading zero digits.
module hex_display_sched
    import hex_disp_pkg::*;
#(
    parameter int NSRC   = 4,
    parameter int DIGITS = 6,
    parameter int DWELL  = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NSRC*DIGITS*4-1:0]   src_data,
    input  logic [NSRC-1:0]            src_valid,
    input  logic                       hold,
    input  logic                       adv,
    output logic [$clog2(NSRC)-1:0]    cur_src,
    output logic                       showing,
    output logic [DIGITS*7-1:0]        hex_out
);
    localparam int SW = $clog2(NSRC);
    localparam int DW = DIGITS * 4;
    localparam int HW = DIGITS * 7;
    localparam logic [SW-1:0] LAST_SRC = SW'(NSRC - 1);

    sched_state_t state, state_nxt;
    logic [SW-1:0] cand;
    logic [SW-1:0] tried;
    logic [DW-1:0] snapshot;
    logic          expire;
    logic          leave_show;
    logic          cand_hit;

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] i);
        return (i == LAST_SRC) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [HW-1:0] render(input logic [DW-1:0] v);
        logic [HW-1:0] res;
`ifdef HEX_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        res = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
`ifdef HEX_ZERO_BLANK_EN
            if (lead && d != 0 && v[d*4 +: 4] == 4'h0) begin
                res[d*7 +: 7] = SEG_BLANK;
            end else begin
                lead = 1'b0;
                res[d*7 +: 7] = nibble_to_seg(v[d*4 +: 4]);
            end
`else
            res[d*7 +: 7] = nibble_to_seg(v[d*4 +: 4]);
`endif
        end
        return res;
    endfunction

    assign cand_hit   = src_valid[cand];
    // A vanished source forces a reseek even under hold
    assign leave_show = !src_valid[cur_src] || (!hold && (expire || adv));

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == SEEK && cand_hit),
        .en     (state == SHOW && !hold),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|src_valid) state_nxt = SEEK;
            SEEK: begin
                if (cand_hit)
                    state_nxt = SHOW;
                else if (tried == LAST_SRC)
                    state_nxt = IDLE;
            end
            SHOW: if (leave_show) state_nxt = SEEK;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        showing = (state == SHOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_src  <= '0;
            cand     <= '0;
            tried    <= '0;
            snapshot <= '0;
            hex_out  <= {DIGITS{SEG_BLANK}};
        end else begin
            case (state)
                IDLE: begin
                    cand    <= cur_src;
                    tried   <= '0;
                    hex_out <= {DIGITS{SEG_BLANK}};
                end
                SEEK: begin
                    if (cand_hit) begin
                        cur_src  <= cand;
                        snapshot <= src_data[int'(cand)*DW +: DW];
                    end else begin
                        cand  <= wrap_inc(cand);
                        tried <= tried + 1'b1;
                    end
                end
                SHOW: begin
                    snapshot <= src_data[int'(cur_src)*DW +: DW];
                    hex_out  <= render(snapshot);
                    if (leave_show) begin
                        cand  <= wrap_inc(cur_src);
                        tried <= '0;
                    end
                end
                default: begin
                    cand <= cur_src;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_sched.sv
// Bench for hex_display_sched: directed scenarios plus randomized traffic against a cycle model.
module tb_hex_display_sched;
    localparam int NSRC = 4, DIGITS = 6, DWELL = 4;
    localparam int DW = DIGITS * 4, HW = DIGITS * 7;
    localparam logic [HW-1:0] BLANK = {DIGITS{7'h7F}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [NSRC*DW-1:0]   src_data;
    logic [NSRC-1:0]      src_valid;
    logic                 hold, adv;
    logic [1:0]           cur_src;
    logic                 showing;
    logic [HW-1:0]        hex_out;

    hex_display_sched #(.NSRC(NSRC), .DIGITS(DIGITS), .DWELL(DWELL)) dut (
        .clk(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
        .hold(hold), .adv(adv), .cur_src(cur_src), .showing(showing), .hex_out(hex_out)
    );

    int checks = 0, passed = 0;

    // model: mode 0 = blank/idle, 1 = showing, 2 = searching
    int m_mode, m_cur, m_cnt, m_cand, m_tried;
    logic [DW-1:0] m_snap;
    logic [HW-1:0] m_hex;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [HW-1:0] render(input logic [DW-1:0] v);
        logic [HW-1:0] r;
        int sig;
        sig = DIGITS;
`ifdef HEX_ZERO_BLANK_EN
        sig = 1;
        for (int d = 0; d < DIGITS; d++)
            if (v[d*4 +: 4] != 4'h0) sig = d + 1;
`endif
        for (int d = 0; d < DIGITS; d++)
            r[d*7 +: 7] = (d < sig) ? glyph[v[d*4 +: 4]] : 7'h7F;
        return r;
    endfunction

    task automatic model_step();
        int mode, cur, cnt, cand, tried;
        logic [DW-1:0] snap;
        logic [HW-1:0] hx;
        bit leave;
        if (reset) begin
            m_mode = 0; m_cur = 0; m_cnt = 0; m_cand = 0; m_tried = 0;
            m_snap = '0; m_hex = BLANK;
            return;
        end
        hx = (m_mode == 1) ? render(m_snap) : (m_mode == 0) ? BLANK : m_hex;
        mode = m_mode; cur = m_cur; cnt = m_cnt; cand = m_cand; tried = m_tried; snap = m_snap;
        case (m_mode)
            0: if (src_valid != 0) begin mode = 2; cand = m_cur; tried = 0; end
            2: begin
                if (src_valid[m_cand]) begin
                    cur = m_cand; snap = src_data[m_cand*DW +: DW]; cnt = 0; mode = 1;
                end else begin
                    tried = m_tried + 1;
                    cand = (m_cand + 1) % NSRC;
                    if (tried == NSRC) mode = 0;
                end
            end
            default: begin
                snap = src_data[m_cur*DW +: DW];
                leave = !src_valid[m_cur] || (!hold && (m_cnt == DWELL - 1 || adv));
                if (!hold) cnt = (m_cnt + 1) % DWELL;
                if (leave) begin mode = 2; cand = (m_cur + 1) % NSRC; tried = 0; end
            end
        endcase
        m_mode = mode; m_cur = cur; m_cnt = cnt; m_cand = cand; m_tried = tried;
        m_snap = snap; m_hex = hx;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("cur_src", 64'(cur_src), 64'(m_cur));
        check("showing", 64'(showing), 64'(m_mode == 1));
        check("hex_out", 64'(hex_out), 64'(m_hex));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    logic [HW-1:0] exp_lit;

    initial begin
        reset = 1'b1; hold = 1'b0; adv = 1'b0; src_valid = 4'b1111;
        src_data = {$urandom, $urandom, $urandom};
        src_data[23:0] = 24'h123456;
        #1;
        cycles(3);
        check("rst_hex", 64'(hex_out), 64'(BLANK));
        check("rst_cur", 64'(cur_src), 64'd0);
        check("rst_showing", 64'(showing), 64'd0);
        reset = 1'b0;
        cycle();
        check("post_rst_hex", 64'(hex_out), 64'(BLANK));
        check("post_rst_showing", 64'(showing), 64'd0);
        cycles(2);
        exp_lit = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
        check("hex_123456", 64'(hex_out), 64'(exp_lit));
        check("first_src", 64'(cur_src), 64'd0);
        cycles(4);
        check("dwell_adv_1", 64'(cur_src), 64'd1);

        // skip invalid sources 1 and 2
        src_valid = 4'b1001;
        do_reset();
        cycles(8);
        check("skip_mid_cur", 64'(cur_src), 64'd0);
        check("skip_mid_showing", 64'(showing), 64'd0);
        cycle();
        check("skip_to_3", 64'(cur_src), 64'd3);
        cycles(5);
        check("wrap_to_0", 64'(cur_src), 64'd0);

        // hold masks adv and expiry
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            adv = (i % 5 == 2);
            cycle();
        end
        adv = 1'b0;
        check("hold_cur", 64'(cur_src), 64'd0);
        check("hold_showing", 64'(showing), 64'd1);
        src_valid = 4'b1000;
        cycle();
        check("drop_under_hold", 64'(showing), 64'd0);
        hold = 1'b0;
        cycles(4);

        // adv coinciding with expiry advances once
        src_valid = 4'b0111;
        do_reset();
        cycles(5);
        adv = 1'b1; cycle(); adv = 1'b0;
        cycle();
        check("adv_exp_cur", 64'(cur_src), 64'd1);
        cycle();
        check("adv_exp_cur2", 64'(cur_src), 64'd1);
        check("adv_exp_showing", 64'(showing), 64'd1);

        // all sources vanish: four seek cycles then blank
        src_valid = 4'b0000;
        cycles(5);
        check("seek_exhaust_showing", 64'(showing), 64'd0);
        cycle();
        check("idle_blank", 64'(hex_out), 64'(BLANK));

        // leading zero handling
        src_data[23:0] = 24'h0000A0;
        src_valid = 4'b0001;
        cycles(8);
`ifdef HEX_ZERO_BLANK_EN
        exp_lit = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40};
`else
        exp_lit = {7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40};
`endif
        check("hex_A0", 64'(hex_out), 64'(exp_lit));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) src_valid = 4'($urandom);
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            adv = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) begin
                int s;
                s = $urandom_range(0, NSRC - 1);
                src_data[s*DW +: DW] = 24'($urandom >> $urandom_range(0, 31));
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
